// File: rtl/debounce_bank.sv
// Multi-channel debouncer: two-flop synchroniser, stability filter, rise/fall strobes
// and a long-press detector timed by one prescaler shared across all channels.
module debounce_bank #(
  parameter int unsigned  N     = 4,
  parameter int unsigned  DELAY = 270000,
  parameter int unsigned  TICK  = 27000,
  parameter int unsigned  HOLD  = 1000,
  parameter logic [N-1:0] IDLE  = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] noisy,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] held,
  output logic [N-1:0] long_press
);

  localparam int unsigned CW = $clog2(DELAY + 1);
  localparam int unsigned TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned HW = $clog2(HOLD + 1);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  cand;
  logic [CW-1:0] count    [N];
  logic [HW-1:0] hold_cnt [N];
  logic [TW-1:0] tick_cnt;

  logic          tick_c;
  logic [N-1:0]  clean_c;
  logic [N-1:0]  active_c;
  logic [N-1:0]  active_next_c;

  assign tick_c = (tick_cnt == TW'(TICK - 1));

  // A channel commits its candidate only after the window has fully elapsed with no change.
  always_comb begin
    clean_c = clean;
    for (int i = 0; i < int'(N); i++) begin
      if ((sync2[i] == cand[i]) && (count[i] == CW'(DELAY))) begin
        clean_c[i] = cand[i];
      end
    end
  end

  assign active_c      = clean ^ IDLE;
  assign active_next_c = clean_c ^ IDLE;

  // Shared prescaler
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Synchroniser, stability filter and edge strobes
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
      cand  <= IDLE;
      clean <= IDLE;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < int'(N); i++) begin
        count[i] <= '0;
      end
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      clean <= clean_c;
      rise  <= clean_c & ~clean;
      fall  <= ~clean_c & clean;
      for (int i = 0; i < int'(N); i++) begin
        if (sync2[i] != cand[i]) begin
          cand[i]  <= sync2[i];
          count[i] <= '0;
        end else if (count[i] != CW'(DELAY)) begin
          count[i] <= count[i] + CW'(1);
        end
      end
    end
  end

  // Long-press timing: only ticks seen after the channel was already active are counted,
  // and going inactive clears held on the same edge clean returns to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      held       <= '0;
      long_press <= '0;
      for (int i = 0; i < int'(N); i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      long_press <= '0;
      for (int i = 0; i < int'(N); i++) begin
        if (!active_c[i] || !active_next_c[i]) begin
          hold_cnt[i] <= '0;
          held[i]     <= 1'b0;
        end else if (tick_c && (hold_cnt[i] < HW'(HOLD))) begin
          hold_cnt[i] <= hold_cnt[i] + HW'(1);
          if (hold_cnt[i] == HW'(HOLD - 1)) begin
            held[i]       <= 1'b1;
            long_press[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: strobe events are predicted into a scoreboard
// when stimulus is applied and matched against the DUT strobes as they appear.
module tb_debounce_bank;

  localparam int N     = 2;
  localparam int DELAY = 4;
  localparam int TICK  = 3;
  localparam int HOLD  = 2;
  localparam logic [1:0] IDLE = 2'b10;
  localparam int RESP  = DELAY + 4;
  localparam int RISE  = 0;
  localparam int FALL  = 1;
  localparam int LONG  = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] noisy;
  logic [1:0] clean;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] held;
  logic [1:0] long_press;

  int  cyc      = 0;
  int  rst_edge = 0;
  int  errors   = 0;
  int  checks   = 0;
  int  pend     = 0;
  ev_t sb[$];

  debounce_bank #(
    .N(N), .DELAY(DELAY), .TICK(TICK), .HOLD(HOLD), .IDLE(IDLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .noisy(noisy),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .held(held),
    .long_press(long_press)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) rst_edge <= cyc + 1;
  end

  // Scoreboard matcher: every observed strobe must have been predicted for this cycle.
  always @(negedge clock) begin
    logic [1:0] s;
    bit hit;
    for (int k = 0; k < 3; k++) begin
      s = (k == RISE) ? rise : ((k == FALL) ? fall : long_press);
      for (int ch = 0; ch < N; ch++) begin
        if (s[ch]) begin
          checks++;
          hit = 1'b0;
          for (int j = sb.size() - 1; j >= 0; j--) begin
            if (!hit && sb[j].cyc == cyc && sb[j].ch == ch && sb[j].kind == k) begin
              sb.delete(j);
              hit = 1'b1;
            end
          end
          if (!hit) begin
            errors++;
            $display("FAIL strobe_unexpected kind=%0d ch=%0d cycle=%0d: got pulse, required none", k, ch, cyc);
          end
        end
      end
    end
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing kind=%0d ch=%0d: required at cycle %0d, not observed by cycle %0d",
                 sb[j].kind, sb[j].ch, sb[j].cyc, cyc);
        sb.delete(j);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input int c, input int ch, input int k);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = k;
    sb.push_back(e);
  endtask

  // Edge of the HOLD-th prescaler wrap strictly after the channel became active at edge e.
  function automatic int lp(input int e);
    int n;
    int r;
    n = 0;
    r = -1;
    for (int t = e + 1; t <= e + (HOLD + 1) * TICK; t++) begin
      if (r < 0 && ((t - rst_edge) % TICK) == 0) begin
        n++;
        if (n == HOLD) r = t;
      end
    end
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    noisy = IDLE;
    step(5);
    reset = 1'b0;
    checks++; if (clean !== IDLE) begin errors++; $display("FAIL reset_clean got %b required %b", clean, IDLE); end
    checks++; if (rise !== 2'b00) begin errors++; $display("FAIL reset_rise got %b required 00", rise); end
    checks++; if (fall !== 2'b00) begin errors++; $display("FAIL reset_fall got %b required 00", fall); end
    checks++; if (held !== 2'b00) begin errors++; $display("FAIL reset_held got %b required 00", held); end
    checks++; if (long_press !== 2'b00) begin errors++; $display("FAIL reset_long got %b required 00", long_press); end
    step(20);
    checks++; if (clean !== IDLE) begin errors++; $display("FAIL idle_clean got %b required %b", clean, IDLE); end
  endtask

  task automatic test_rise_hold;
    int c, e, l;
    c = cyc;
    noisy[0] = 1'b1;
    e = c + RESP;
    l = lp(e);
    push(e, 0, RISE);
    push(l, 0, LONG);
    step(RESP - 1);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL rise_early clean got %b required 10", clean); end
    step(1);
    checks++; if (clean !== 2'b11) begin errors++; $display("FAIL rise_clean got %b required 11", clean); end
    checks++; if (rise !== 2'b01) begin errors++; $display("FAIL rise_strobe got %b required 01", rise); end
    step(1);
    checks++; if (rise !== 2'b00) begin errors++; $display("FAIL rise_width got %b required 00", rise); end
    step(l - 1 - cyc);
    checks++; if (held !== 2'b00) begin errors++; $display("FAIL held_early got %b required 00", held); end
    step(1);
    checks++; if (held !== 2'b01) begin errors++; $display("FAIL held_rise got %b required 01", held); end
    checks++; if (long_press !== 2'b01) begin errors++; $display("FAIL long_strobe got %b required 01", long_press); end
    step(1);
    checks++; if (long_press !== 2'b00) begin errors++; $display("FAIL long_width got %b required 00", long_press); end
    checks++; if (held !== 2'b01) begin errors++; $display("FAIL held_stay got %b required 01", held); end
    c = cyc;
    noisy[0] = 1'b0;
    push(c + RESP, 0, FALL);
    step(RESP - 1);
    checks++; if (held !== 2'b01) begin errors++; $display("FAIL held_before_release got %b required 01", held); end
    step(1);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL release_clean got %b required 10", clean); end
    checks++; if (held !== 2'b00) begin errors++; $display("FAIL release_held got %b required 00", held); end
    checks++; if (fall !== 2'b01) begin errors++; $display("FAIL release_fall got %b required 01", fall); end
    step(4);
  endtask

  task automatic test_glitch;
    int c, e, f, l;
    noisy[0] = 1'b1;
    step(DELAY);
    noisy[0] = 1'b0;
    step(RESP + 2);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL glitch_short clean got %b required 10", clean); end
    // DELAY+1 high clocks still lets the mismatch restart the window before commit.
    noisy[0] = 1'b1;
    step(DELAY + 1);
    noisy[0] = 1'b0;
    step(RESP + 2);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL glitch_edge clean got %b required 10", clean); end
    c = cyc;
    noisy[0] = 1'b1;
    e = c + RESP;
    push(e, 0, RISE);
    step(DELAY + 2);
    noisy[0] = 1'b0;
    f = cyc + RESP;
    push(f, 0, FALL);
    l = lp(e);
    if (l < f) push(l, 0, LONG);
    step(RESP);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL pulse_clean got %b required 10", clean); end
    checks++; if (fall !== 2'b01) begin errors++; $display("FAIL pulse_fall got %b required 01", fall); end
    step(4);
  endtask

  task automatic test_idle_high;
    int c, e, d;
    c = cyc;
    noisy[1] = 1'b0;
    e = c + RESP;
    push(e, 1, FALL);
    push(lp(e), 1, LONG);
    step(RESP);
    checks++; if (clean !== 2'b00) begin errors++; $display("FAIL ch1_clean got %b required 00", clean); end
    checks++; if (fall !== 2'b10) begin errors++; $display("FAIL ch1_fall got %b required 10", fall); end
    d = -1;
    for (int i = 1; i <= HOLD * TICK + 2; i++) begin
      step(1);
      if (held[1] === 1'b1 && d < 0) d = i;
    end
    checks++;
    if (d < (HOLD - 1) * TICK + 1 || d > HOLD * TICK) begin
      errors++;
      $display("FAIL ch1_held_delay got %0d required %0d..%0d", d, (HOLD - 1) * TICK + 1, HOLD * TICK);
    end
    checks++; if (held !== 2'b10) begin errors++; $display("FAIL ch1_held got %b required 10", held); end
    c = cyc;
    noisy[1] = 1'b1;
    push(c + RESP, 1, RISE);
    step(RESP - 1);
    checks++; if (held !== 2'b10) begin errors++; $display("FAIL ch1_held_pre got %b required 10", held); end
    step(1);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL ch1_release got %b required 10", clean); end
    checks++; if (held !== 2'b00) begin errors++; $display("FAIL ch1_held_drop got %b required 00", held); end
    checks++; if (rise !== 2'b10) begin errors++; $display("FAIL ch1_rise got %b required 10", rise); end
    step(4);
  endtask

  task automatic test_bounce;
    int c, e;
    for (int i = 0; i < 50; i++) begin
      if (i % 3 == 0) noisy[0] = ~noisy[0];
      step(1);
    end
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL bounce_clean got %b required 10", clean); end
    noisy[0] = 1'b0;
    step(RESP);
    c = cyc;
    noisy[0] = 1'b1;
    e = c + RESP;
    push(e, 0, RISE);
    pend = lp(e);
    push(pend, 0, LONG);
    step(RESP);
    checks++; if (clean !== 2'b11) begin errors++; $display("FAIL bounce_settle got %b required 11", clean); end
    checks++; if (rise !== 2'b01) begin errors++; $display("FAIL bounce_rise got %b required 01", rise); end
  endtask

  task automatic test_reset_mid;
    int c, e;
    if (cyc <= pend) step(pend - cyc + 1);
    checks++; if (held !== 2'b01) begin errors++; $display("FAIL pre_reset_held got %b required 01", held); end
    reset = 1'b1;
    step(1);
    checks++; if (clean !== IDLE) begin errors++; $display("FAIL rst_held_clean got %b required %b", clean, IDLE); end
    checks++; if ({rise, fall, held, long_press} !== 8'h00) begin
      errors++; $display("FAIL rst_held_outs got %b required 00000000", {rise, fall, held, long_press});
    end
    step(2);
    reset = 1'b0;
    c = cyc;
    e = c + RESP;
    push(e, 0, RISE);
    pend = lp(e);
    push(pend, 0, LONG);
    step(RESP - 1);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL rst_rel_early got %b required 10", clean); end
    step(1);
    checks++; if (rise !== 2'b01) begin errors++; $display("FAIL rst_rel_rise got %b required 01", rise); end
    if (cyc <= pend) step(pend - cyc + 1);
    noisy[0] = 1'b0;
    step(DELAY);
    reset = 1'b1;
    step(1);
    checks++; if (clean !== IDLE) begin errors++; $display("FAIL rst_mid_clean got %b required %b", clean, IDLE); end
    checks++; if ({rise, fall, held, long_press} !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outs got %b required 00000000", {rise, fall, held, long_press});
    end
    reset = 1'b0;
    c = cyc;
    noisy[0] = 1'b1;
    e = c + RESP;
    push(e, 0, RISE);
    pend = lp(e);
    push(pend, 0, LONG);
    step(RESP);
    checks++; if (rise !== 2'b01) begin errors++; $display("FAIL rst_mid_rise got %b required 01", rise); end
    if (cyc <= pend) step(pend - cyc + 1);
    c = cyc;
    noisy[0] = 1'b0;
    push(c + RESP, 0, FALL);
    step(RESP);
    checks++; if (clean !== 2'b10) begin errors++; $display("FAIL final_clean got %b required 10", clean); end
  endtask

  initial begin
    reset = 1'b1;
    noisy = IDLE;
    test_reset;
    test_rise_hold;
    test_glitch;
    test_idle_high;
    test_bounce;
    test_reset_mid;
    step(2 * RESP);
    foreach (sb[j]) begin
      checks++;
      errors++;
      $display("FAIL strobe_pending kind=%0d ch=%0d: required at cycle %0d, never seen", sb[j].kind, sb[j].ch, sb[j].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
